// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared types and constants for the regbank loader
package regbank_pkg;

    // Frame parser states; HDR_HI doubles as idle
    typedef enum logic [2:0] {
        ST_HDR_HI,
        ST_HDR_LO,
        ST_HDR_CNT,
        ST_DATA,
        ST_WRITE
    } loader_state_t;

    // Words-remaining counter width: holds 1..256
    localparam int CNT_W = 9;

    // Byte offsets of the frame header fields
    localparam int FRM_ADDR_HI = 0;
    localparam int FRM_ADDR_LO = 1;
    localparam int FRM_COUNT   = 2;
    localparam int FRM_HDR_LEN = 3;

    function automatic int bytes_of(input int word_width);
        return word_width / 8;
    endfunction

    // Byte index width, never narrower than one bit
    function automatic int bidx_w_of(input int n_bytes);
        return (n_bytes > 2) ? $clog2(n_bytes) : 1;
    endfunction

    // Defaults for the standard 32-bit regbank
    localparam int BYTES  = bytes_of(32);
    localparam int BIDX_W = bidx_w_of(BYTES);

endpackage

// File: rtl/regbank_loader_if.sv
// rtl/regbank_loader_if.sv - byte stream in, regbank write port out
interface regbank_loader_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_WIDTH = 32
);
    logic                  i_valid;
    logic [7:0]            i_data;
    logic                  o_ready;
    logic                  o_write;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [WORD_WIDTH-1:0] o_value;

    // Loader side: sinks bytes, sources regbank writes
    modport slave (
        input  i_valid, i_data,
        output o_ready, o_write, o_addr, o_value
    );

    // Feeder side: sources bytes, observes regbank writes
    modport master (
        output i_valid, i_data,
        input  o_ready, o_write, o_addr, o_value
    );
endinterface

// File: rtl/regbank_loader_timeout.sv
// rtl/regbank_loader_timeout.sv - idle watchdog with one-cycle expire pulse
module regbank_loader_timeout #(
    parameter int TIMEOUT = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    input  logic i_kick,
    output logic o_expire
);
    localparam int            CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT   = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit            ENABLED = (TIMEOUT > 0);

    logic [CW-1:0] r_cnt;

    // Expire fires on the TIMEOUT-th consecutive idle cycle
    assign o_expire = ENABLED && i_enable && !i_kick && (r_cnt == LIMIT);

    // Count idle cycles; any kick, disable or expiry restarts from zero
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_enable || i_kick || o_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/regbank_loader.sv
// rtl/regbank_loader.sv - parses burst-write frames into regbank word writes
module regbank_loader
    import regbank_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                i_clk,
    input  logic                i_rst,
    regbank_loader_if.slave     bus,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_timeout
);
    localparam int BYTES_N = bytes_of(WORD_WIDTH);
    localparam int BIDX_N  = bidx_w_of(BYTES_N);

    loader_state_t         r_state;
    loader_state_t         w_next;
    logic [7:0]            r_hi;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_W-1:0]      r_words;
    logic [BIDX_N-1:0]     r_bidx;
    logic [WORD_WIDTH-1:0] r_asm;
    logic [WORD_WIDTH-1:0] w_word;
    logic                  r_write;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_o_addr;
    logic [WORD_WIDTH-1:0] r_o_value;
    logic                  w_accept;
    logic                  w_last_byte;
    logic                  w_expire;
    logic                  w_kick;

    assign bus.o_ready  = !i_rst && (r_state != ST_WRITE);
    assign w_accept     = bus.i_valid && bus.o_ready;
    assign w_last_byte  = (r_bidx == BIDX_N'(BYTES_N - 1));
    assign w_kick       = w_accept || (r_state == ST_WRITE);

    assign o_busy       = (r_state != ST_HDR_HI);
    assign o_done       = r_done;
    assign o_timeout    = w_expire;
    assign bus.o_write  = r_write;
    assign bus.o_addr   = r_o_addr;
    assign bus.o_value  = r_o_value;

    regbank_loader_timeout #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_enable (o_busy),
        .i_kick   (w_kick),
        .o_expire (w_expire)
    );

    // Assembly register with the incoming byte merged at the current index
    always_comb begin
        w_word = r_asm;
        w_word[{r_bidx, 3'b000} +: 8] = bus.i_data;
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_HDR_HI;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: walk the header, gather words, abort to idle on watchdog expiry
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_HDR_HI:  if (w_accept) w_next = ST_HDR_LO;
            ST_HDR_LO:  if (w_expire) w_next = ST_HDR_HI;
                        else if (w_accept) w_next = ST_HDR_CNT;
            ST_HDR_CNT: if (w_expire) w_next = ST_HDR_HI;
                        else if (w_accept) w_next = ST_DATA;
            ST_DATA:    if (w_expire) w_next = ST_HDR_HI;
                        else if (w_accept && w_last_byte) w_next = ST_WRITE;
            ST_WRITE:   w_next = (r_words == CNT_W'(1)) ? ST_HDR_HI : ST_DATA;
            default:    w_next = ST_HDR_HI;
        endcase
    end

    // Header latching, word assembly and the registered regbank write port
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hi      <= '0;
            r_addr    <= '0;
            r_words   <= '0;
            r_bidx    <= '0;
            r_asm     <= '0;
            r_write   <= 1'b0;
            r_done    <= 1'b0;
            r_o_addr  <= '0;
            r_o_value <= '0;
        end else begin
            r_write <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_HDR_HI: if (w_accept) r_hi <= bus.i_data;
                ST_HDR_LO: if (w_accept) r_addr <= ADDR_WIDTH'({r_hi, bus.i_data});
                ST_HDR_CNT: if (w_accept) begin
                    r_words <= (bus.i_data == 8'd0) ? CNT_W'(256) : {1'b0, bus.i_data};
                    r_bidx  <= '0;
                end
                ST_DATA: if (w_accept) begin
                    r_asm <= w_word;
                    if (w_last_byte) begin
                        r_bidx    <= '0;
                        r_write   <= 1'b1;
                        r_o_addr  <= r_addr;
                        r_o_value <= w_word;
                        r_done    <= (r_words == CNT_W'(1));
                    end else begin
                        r_bidx <= r_bidx + BIDX_N'(1);
                    end
                end
                ST_WRITE: begin
                    r_addr  <= r_addr + ADDR_WIDTH'(1);
                    r_words <= r_words - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_regbank_loader.sv
// tb/tb_regbank_loader.sv - randomized scoreboard bench for regbank_loader
module tb_regbank_loader;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst;
    logic busy, done, tmo;

    always #5 clk = ~clk;

    regbank_loader_if #(.ADDR_WIDTH(12), .WORD_WIDTH(32)) bus ();

    regbank_loader #(.ADDR_WIDTH(12), .WORD_WIDTH(32), .TIMEOUT(TMO)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .bus       (bus),
        .o_busy    (busy),
        .o_done    (done),
        .o_timeout (tmo)
    );

    typedef struct {
        logic [11:0] addr;
        logic [31:0] value;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] wq[$];
    int checks   = 0;
    int failures = 0;
    int timeouts = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every regbank write against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (tmo) timeouts++;
            if (bus.o_write || !bus.o_ready)
                chk("ready_low_only_in_write", {31'd0, bus.o_ready}, {31'd0, !bus.o_write});
            if (done && !bus.o_write)
                chk("done_without_write", {31'd0, bus.o_write}, 32'd1);
            if (bus.o_write) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write_addr", {20'd0, bus.o_addr}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("write_addr", {20'd0, bus.o_addr}, {20'd0, e.addr});
                    chk("write_value", bus.o_value, e.value);
                    chk("write_done", {31'd0, done}, {31'd0, e.last});
                end
            end
        end
    end

    // Offer one byte and hold it until the loader takes it
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.i_valid = 1'b1;
        bus.i_data  = b;
        forever begin
            @(negedge clk);
            if (bus.o_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            n++;
            if (n > 50) begin
                chk("byte_accept_stalled", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        bus.i_valid = 1'b0;
        bus.i_data  = 8'($urandom);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gap(input int gmax);
        int g;
        g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
        if (g > 0) idle(g);
    endtask

    // Reference model: a frame at address A with N words writes word i to (A mod 4096 + i) mod 4096
    task automatic send_frame(input logic [15:0] a, input int n, input int gmax);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.addr  = 12'(((a % 4096) + i) % 4096);
            e.value = wq[i];
            e.last  = (i == n - 1);
            sb.push_back(e);
        end
        send_byte(a[15:8]); gap(gmax);
        send_byte(a[7:0]);  gap(gmax);
        send_byte(8'(n % 256));
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                gap(gmax);
                send_byte(8'((wq[i] >> (8 * k)) % 256));
            end
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, bus.o_ready}, 32'd0);
        chk({tag, "_write"}, {31'd0, bus.o_write}, 32'd0);
        chk({tag, "_addr"},  {20'd0, bus.o_addr}, 32'd0);
        chk({tag, "_value"}, bus.o_value, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
        chk({tag, "_done"},  {31'd0, done}, 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, bus.o_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL global_time_limit actual=expired required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int k;
        int n;
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        release_reset();

        // Basic single-word write
        wq = '{32'hDEADBEEF};
        send_frame(16'h0010, 1, 0);
        @(negedge clk);
        chk("busy_in_write", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        idle(2);

        // Burst across the top of the address space, continuous valid
        wq = '{32'h11111111, 32'h22222222, 32'h33333333};
        send_frame(16'h0FFE, 3, 0);
        idle(3);

        // Two-word frame under continuous valid
        wq = '{$urandom, $urandom};
        send_frame(16'h0123, 2, 0);
        idle(3);

        // COUNT=0 means 256 words
        wq.delete();
        for (int i = 0; i < 256; i++) wq.push_back($urandom);
        send_frame(16'h0000, 256, 0);
        idle(3);

        // Timeout mid-word: no write, pulse on idle cycle TMO
        send_byte(8'h00); send_byte(8'h05); send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB);
        bus.i_valid = 1'b0;
        k = 0;
        for (int c = 1; c <= 3 * TMO; c++) begin
            @(negedge clk);
            if (tmo) begin
                k = c;
                break;
            end
            @(posedge clk); #1;
        end
        chk("timeout_idle_cycle", k, TMO);
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_after_timeout", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        wq = '{32'h04030201};
        send_frame(16'h0005, 1, 0);
        idle(3);

        // Reset in the middle of a word
        send_byte(8'h00); send_byte(8'h20); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22);
        bus.i_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        release_reset();
        wq = '{$urandom};
        send_frame(16'h0020, 1, 0);
        idle(2);

        // Randomized frames with random gaps and high address bits
        for (int f = 0; f < 20; f++) begin
            n = int'($urandom_range(1, 5));
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            send_frame(16'($urandom), n, 3);
            idle(int'($urandom_range(0, 4)));
        end

        for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
        idle(2);
        chk("scoreboard_drained", sb.size(), 0);
        chk("timeout_pulse_count", timeouts, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
